// File: rtl/div5_pkg.sv
// Shared defaults and elaboration helpers for the div5 clock divider.
package div5_pkg;

    localparam int unsigned DefaultDiv  = 5;
    localparam int unsigned DefaultCntW = 32;

    // Number of whole clk periods the divided clock spends high on the posedge flop.
    function automatic int unsigned half_period(input int unsigned div);
        return div / 2;
    endfunction

    function automatic bit div_valid(input int unsigned div);
        return div >= 2;
    endfunction

endpackage

// File: rtl/clk_div_gen.sv
// Divide-by-DIV clock generator with 50% duty for odd and even ratios.
// Also emits a strobe on the clk cycle where the phase counter wraps.
module clk_div_gen
    import div5_pkg::*;
#(
    parameter int unsigned DIV = DefaultDiv
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic clk_div_o,
    output logic wrap_o
);

    localparam int unsigned PhW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PhW-1:0] PhMax = PhW'(DIV - 1);
    localparam logic [PhW-1:0] Half  = PhW'(half_period(DIV));

    if (!div_valid(DIV)) begin : g_div_check
        $error("clk_div_gen: DIV must be at least 2");
    end

    logic [PhW-1:0] ph_q, ph_d;
    logic           p_q;

    assign wrap_o = (ph_q == PhMax);
    assign ph_d   = wrap_o ? '0 : ph_q + PhW'(1);

    // Resetting to the last phase makes the first post-reset edge a clean rising edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ph_q <= PhMax;
            p_q  <= 1'b0;
        end else begin
            ph_q <= ph_d;
            p_q  <= (ph_d < Half);
        end
    end

    if (DIV % 2 == 1) begin : g_odd
        logic n_q;

        // Half-cycle extension stretches the high time to H+0.5 periods.
        always_ff @(negedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                n_q <= 1'b0;
            end else begin
                n_q <= p_q;
            end
        end

        assign clk_div_o = p_q | n_q;
    end else begin : g_even
        assign clk_div_o = p_q;
    end

endmodule

// File: rtl/div5.sv
// Clock divider top: divided clock plus input-edge and divided-edge event counters.
// Define DIV5_CNT_SAT_EN to make both counters saturate instead of wrapping.
module div5
    import div5_pkg::*;
#(
    parameter int unsigned DIV   = DefaultDiv,
    parameter int unsigned CNT_W = DefaultCntW
) (
    input  logic             clk,
    input  logic             rst,
    output logic             clk_div5,
    output logic [CNT_W-1:0] clk_cnt,
    output logic [CNT_W-1:0] clk_div5_cnt
);

    logic             wrap;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

    clk_div_gen #(
        .DIV (DIV)
    ) u_clk_div_gen (
        .clk_i     (clk),
        .rst_ni    (rst),
        .clk_div_o (clk_div5),
        .wrap_o    (wrap)
    );

    // Divided-clock edges are counted via the wrap strobe, so everything stays in clk.
    always_comb begin
        clk_cnt_d = clk_cnt_q + CNT_W'(1);
        div_cnt_d = div_cnt_q;
        if (wrap) begin
            div_cnt_d = div_cnt_q + CNT_W'(1);
        end
`ifdef DIV5_CNT_SAT_EN
        if (clk_cnt_q == '1) begin
            clk_cnt_d = clk_cnt_q;
        end
        if (div_cnt_q == '1) begin
            div_cnt_d = div_cnt_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_cnt_q <= '0;
            div_cnt_q <= '0;
        end else begin
            clk_cnt_q <= clk_cnt_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign clk_cnt      = clk_cnt_q;
    assign clk_div5_cnt = div_cnt_q;

endmodule

// File: tb/tb_div5.sv
// Self-checking bench for div5: table vectors, edge-timing checks, and randomized runs
// against an arithmetic model, across DIV=5/4/3 and a narrow-counter build.
module tb_div5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #25 clk = ~clk;

    logic        d5, d4, d3, dw;
    logic [31:0] c5, dc5, c4, dc4, c3, dc3;
    logic [3:0]  cw, dcw;

    div5 #(.DIV(5), .CNT_W(32)) u_dut5 (
        .clk(clk), .rst(rst), .clk_div5(d5), .clk_cnt(c5), .clk_div5_cnt(dc5)
    );
    div5 #(.DIV(4), .CNT_W(32)) u_dut4 (
        .clk(clk), .rst(rst), .clk_div5(d4), .clk_cnt(c4), .clk_div5_cnt(dc4)
    );
    div5 #(.DIV(3), .CNT_W(32)) u_dut3 (
        .clk(clk), .rst(rst), .clk_div5(d3), .clk_cnt(c3), .clk_div5_cnt(dc3)
    );
    div5 #(.DIV(5), .CNT_W(4)) u_dutw (
        .clk(clk), .rst(rst), .clk_div5(dw), .clk_cnt(cw), .clk_div5_cnt(dcw)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Edge timestamps of the divided clocks.
    time r5_last = 0, r5_prev = 0, f5_last = 0;
    time r4_last = 0, r4_prev = 0, f4_last = 0;
    time r3_last = 0, r3_prev = 0, f3_last = 0;

    always @(posedge d5) begin r5_prev = r5_last; r5_last = $time; end
    always @(negedge d5) f5_last = $time;
    always @(posedge d4) begin r4_prev = r4_last; r4_last = $time; end
    always @(negedge d4) f4_last = $time;
    always @(posedge d3) begin r3_prev = r3_last; r3_last = $time; end
    always @(negedge d3) f3_last = $time;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: 50% duty clock of period DIV, high from the first posedge after release.
    // pos counts half clk periods since that posedge; half=1 means sampled after negedge.
    function automatic logic exp_div(input int unsigned div, input int unsigned k,
                                     input int unsigned half);
        int unsigned pos;
        if (k == 0) return 1'b0;
        pos = (2 * (k - 1) + half) % (2 * div);
        return pos < div;
    endfunction

    function automatic longint unsigned fit(input int unsigned w, input longint unsigned v);
        longint unsigned mx;
        mx = (64'd1 << w) - 64'd1;
`ifdef DIV5_CNT_SAT_EN
        return (v > mx) ? mx : v;
`else
        return v & mx;
`endif
    endfunction

    function automatic longint unsigned exp_dcnt(input int unsigned div, input int unsigned k);
        return longint'((k + div - 1) / div);
    endfunction

    function automatic time high_time(input time rl, input time rp, input time fl);
        return (fl > rl) ? fl - rl : fl - rp;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #5 rst = 1'b1;
    endtask

    task automatic check_all(input int unsigned k, input int unsigned half, input string tag);
        check($sformatf("%s div5 k=%0d h=%0d", tag, k, half), d5, exp_div(5, k, half));
        check($sformatf("%s div4 k=%0d h=%0d", tag, k, half), d4, exp_div(4, k, half));
        check($sformatf("%s div3 k=%0d h=%0d", tag, k, half), d3, exp_div(3, k, half));
        check($sformatf("%s divw k=%0d h=%0d", tag, k, half), dw, exp_div(5, k, half));
        if (half == 0) begin
            check($sformatf("%s cnt5 k=%0d", tag, k), c5, fit(32, k));
            check($sformatf("%s dcnt5 k=%0d", tag, k), dc5, fit(32, exp_dcnt(5, k)));
            check($sformatf("%s dcnt4 k=%0d", tag, k), dc4, fit(32, exp_dcnt(4, k)));
            check($sformatf("%s dcnt3 k=%0d", tag, k), dc3, fit(32, exp_dcnt(3, k)));
            check($sformatf("%s cntw k=%0d", tag, k), cw, fit(4, k));
            check($sformatf("%s dcntw k=%0d", tag, k), dcw, fit(4, exp_dcnt(5, k)));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " div5"}, d5, 0);
        check({tag, " div4"}, d4, 0);
        check({tag, " div3"}, d3, 0);
        check({tag, " divw"}, dw, 0);
        check({tag, " cnt5"}, c5, 0);
        check({tag, " dcnt5"}, dc5, 0);
        check({tag, " cntw"}, cw, 0);
        check({tag, " dcntw"}, dcw, 0);
    endtask

    typedef struct {
        int unsigned     k;
        logic            div;
        longint unsigned cnt;
        longint unsigned dcnt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{k: 0,  div: 1'b0, cnt: 0,  dcnt: 0};
        vecs[1] = '{k: 1,  div: 1'b1, cnt: 1,  dcnt: 1};
        vecs[2] = '{k: 4,  div: 1'b0, cnt: 4,  dcnt: 1};
        vecs[3] = '{k: 5,  div: 1'b0, cnt: 5,  dcnt: 1};
        vecs[4] = '{k: 6,  div: 1'b1, cnt: 6,  dcnt: 2};
        vecs[5] = '{k: 11, div: 1'b1, cnt: 11, dcnt: 3};
        vecs[6] = '{k: 50, div: 1'b0, cnt: 50, dcnt: 10};

        // Table vectors on the default DIV=5 instance.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            repeat (vecs[i].k) @(posedge clk);
            #1;
            check($sformatf("tbl div k=%0d", vecs[i].k), d5, vecs[i].div);
            check($sformatf("tbl cnt k=%0d", vecs[i].k), c5, vecs[i].cnt);
            check($sformatf("tbl dcnt k=%0d", vecs[i].k), dc5, vecs[i].dcnt);
        end

        // Reset state while held.
        rst = 1'b0;
        #1;
        check_zero("reset");

        // Waveform timing: first rise on first posedge, period DIV*50, 50% duty.
        begin
            time tp;
            @(negedge clk);
            #5 rst = 1'b1;
            @(posedge clk);
            tp = $time;
            #1;
            check("first rise div5", r5_last, tp);
            check("first rise div3", r3_last, tp);
            repeat (11) @(posedge clk);
            #1;
            check("period div5", r5_last - r5_prev, 250);
            check("high div5", high_time(r5_last, r5_prev, f5_last), 125);
            check("period div4", r4_last - r4_prev, 200);
            check("high div4", high_time(r4_last, r4_prev, f4_last), 100);
            check("period div3", r3_last - r3_prev, 150);
            check("high div3", high_time(r3_last, r3_prev, f3_last), 75);
            check("div4 cnt k=12", c4, 12);
            check("div4 dcnt k=12", dc4, 3);
        end

        // DIV=3 after 9 posedges.
        do_reset();
        repeat (9) @(posedge clk);
        #1;
        check("div3 dcnt k=9", dc3, 3);

        // Narrow counter: 20 posedges into a 4-bit counter.
        do_reset();
        repeat (20) @(posedge clk);
        #1;
`ifdef DIV5_CNT_SAT_EN
        check("cntw k=20", cw, 15);
`else
        check("cntw k=20", cw, 4);
`endif
        check("dcntw k=20", dcw, 4);

        // Reset asserted at posedge 23 while the divided clock is high.
        do_reset();
        repeat (23) @(posedge clk);
        #1;
        check("pre-reset div5 high", d5, 1);
        #4 rst = 1'b0;
        #1;
        check_zero("mid reset");
        @(negedge clk);
        #5 rst = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("post reset cnt", c5, 7);
        check("post reset dcnt", dc5, 2);

        // Randomized run lengths, checked every half period, ended by a random async reset.
        for (int r = 0; r < 6; r++) begin
            int unsigned n;
            n = $urandom_range(20, 80);
            do_reset();
            #1;
            check_all(0, 0, "rnd");
            for (int unsigned k = 1; k <= n; k++) begin
                @(posedge clk);
                #1;
                check_all(k, 0, "rnd");
                @(negedge clk);
                #1;
                check_all(k, 1, "rnd");
            end
            @(posedge clk);
            #($urandom_range(3, 40));
            rst = 1'b0;
            #1;
            check_zero("rnd async reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
